// File: rtl/bcd_display_scanner_pkg.sv
// Shared library for the BCD display scanner: active-low segment patterns,
// common types and small helpers used by the scanner and its decoder.

`ifndef BCD_DISPLAY_SCANNER_SEG_DEFS
`define BCD_DISPLAY_SCANNER_SEG_DEFS
// Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
`define SEG_0     7'b1000000
`define SEG_1     7'b1111001
`define SEG_2     7'b0100100
`define SEG_3     7'b0110000
`define SEG_4     7'b0011001
`define SEG_5     7'b0010010
`define SEG_6     7'b0000010
`define SEG_7     7'b1111000
`define SEG_8     7'b0000000
`define SEG_9     7'b0010000
`define SEG_ERR   7'b0000110
`define SEG_BLANK 7'b1111111
`endif

package bcd_display_scanner_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  AN_ALL_OFF = 4'b1111;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  typedef logic [1:0] digit_idx_t;

  // Active-low one-hot anode select for a digit slot.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Bundles the scanner's digit inputs, load handshake and display outputs.
// The bench drives through the master view; the scanner uses the slave view.

interface bcd_display_scanner_if;
  import bcd_display_scanner_pkg::*;

  logic en;
  bcd_t dig0;
  bcd_t dig1;
  bcd_t dig2;
  bcd_t dig3;
  logic load;
  logic blank_lz;
  logic busy;
  logic [3:0] an;
  seg_t seg;
  logic frame_done;

  modport master (
    output en, dig0, dig1, dig2, dig3, load, blank_lz,
    input  busy, an, seg, frame_done
  );

  modport slave (
    input  en, dig0, dig1, dig2, dig3, load, blank_lz,
    output busy, an, seg, frame_done
  );

endinterface

// File: rtl/bcd_display_scanner_bcd_to_seg.sv
// Purely combinational BCD to active-low seven-segment decoder.
// Codes above 9 render as 'E' so corrupted digits are visible on the display.

import bcd_display_scanner_pkg::*;

module bcd_to_seg (
  input  bcd_t i_bcd,
  output seg_t o_seg
);

  // Look up the segment pattern for one BCD code.
  always_comb begin
    o_seg = `SEG_ERR;
    case (i_bcd)
      4'd0:    o_seg = `SEG_0;
      4'd1:    o_seg = `SEG_1;
      4'd2:    o_seg = `SEG_2;
      4'd3:    o_seg = `SEG_3;
      4'd4:    o_seg = `SEG_4;
      4'd5:    o_seg = `SEG_5;
      4'd6:    o_seg = `SEG_6;
      4'd7:    o_seg = `SEG_7;
      4'd8:    o_seg = `SEG_8;
      4'd9:    o_seg = `SEG_9;
      default: o_seg = `SEG_ERR;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed BCD display scanner. A prescaler paces the digit
// slots; a shadow register holds the displayed value and is only refreshed at
// frame boundaries so a frame never mixes old and new digits.

import bcd_display_scanner_pkg::*;

module bcd_display_scanner #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_display_scanner_if.slave  bus
);

  localparam int unsigned   CW        = $clog2(PRESCALE);
  localparam logic [CW-1:0] PRESC_MAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] PRESC_ONE = CW'(1);

  logic [CW-1:0]             r_presc;
  digit_idx_t                r_idx;
  bcd_t [NUM_DIGITS-1:0]     r_shadow;
  logic                      r_pending;
  logic [3:0]                r_an;
  seg_t                      r_seg;
  logic                      r_frame_done;

  logic                      w_tick;
  logic                      w_wrap;
  logic                      w_capture;
  digit_idx_t                w_idx_next;
  bcd_t [NUM_DIGITS-1:0]     w_view;
  logic                      w_upper_zero;
  bcd_t                      w_code;
  seg_t                      w_dec_seg;
  seg_t                      w_seg_next;

  assign w_tick     = bus.en && (r_presc == PRESC_MAX);
  assign w_wrap     = w_tick && (r_idx == 2'd3);
  assign w_capture  = w_wrap && (r_pending || bus.load);
  assign w_idx_next = r_idx + 2'd1;

  // Shadow contents as seen by the slot being selected; a capturing wrap
  // shows the freshly loaded digits immediately on digit 0.
  always_comb begin
    w_view = r_shadow;
    if (w_capture) begin
      w_view = {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
    end else begin
      w_view = r_shadow;
    end
  end

  // A digit is a leading zero when it and every more significant digit are 0.
  always_comb begin
    w_upper_zero = 1'b0;
    case (w_idx_next)
      2'd3:    w_upper_zero = (w_view[3] == 4'd0);
      2'd2:    w_upper_zero = (w_view[3] == 4'd0) && (w_view[2] == 4'd0);
      2'd1:    w_upper_zero = (w_view[3] == 4'd0) && (w_view[2] == 4'd0) &&
                              (w_view[1] == 4'd0);
      default: w_upper_zero = 1'b0;
    endcase
  end

  assign w_code = w_view[w_idx_next];

  bcd_to_seg u_bcd_to_seg (
    .i_bcd (w_code),
    .o_seg (w_dec_seg)
  );

  // Choose between the decoded pattern and a blanked leading zero.
  always_comb begin
    w_seg_next = w_dec_seg;
    if (bus.blank_lz && w_upper_zero) begin
      w_seg_next = `SEG_BLANK;
    end else begin
      w_seg_next = w_dec_seg;
    end
  end

  // Prescaler and scan index advance only while the display is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else if (bus.en) begin
      r_presc <= w_tick ? '0 : (r_presc + PRESC_ONE);
      if (w_tick) begin
        r_idx <= w_idx_next;
      end
    end
  end

  // Load request bookkeeping and frame-aligned capture into the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (w_capture) begin
      r_shadow  <= w_view;
      r_pending <= 1'b0;
    end else if (bus.load) begin
      r_pending <= 1'b1;
    end
  end

  // Registered display drive: blank while disabled, refresh on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an         <= AN_ALL_OFF;
      r_seg        <= `SEG_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (!bus.en) begin
        r_an  <= AN_ALL_OFF;
        r_seg <= `SEG_BLANK;
      end else if (w_tick) begin
        r_an  <= an_select(w_idx_next);
        r_seg <= w_seg_next;
      end
    end
  end

  assign bus.busy       = r_pending;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// behavioural display model.

module tb_bcd_display_scanner;

  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n;

  bcd_display_scanner_if dut_if ();

  bcd_display_scanner #(.PRESCALE(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: slot timer, current digit, shown value, pending request.
  int         m_cnt;
  int         m_idx;
  int         m_shadow [4];
  bit         m_pend;
  bit         m_fd;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  function automatic logic [6:0] digit_pattern(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  function automatic logic [6:0] model_shown(input int i);
    bit lead;
    if (dut_if.blank_lz && i > 0) begin
      lead = 1'b1;
      for (int j = i; j < 4; j++) if (m_shadow[j] != 0) lead = 1'b0;
      if (lead) return 7'b1111111;
    end
    return digit_pattern(m_shadow[i]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_pend = 1'b0; m_fd = 1'b0;
    for (int k = 0; k < 4; k++) m_shadow[k] = 0;
    m_an  = 4'hF;
    m_seg = 7'h7F;
  endtask

  task automatic model_step();
    bit tick, wrap;
    tick = dut_if.en && (m_cnt == P - 1);
    wrap = tick && (m_idx == 3);
    m_fd = wrap;
    if (dut_if.en) m_cnt = tick ? 0 : m_cnt + 1;
    if (wrap && (m_pend || dut_if.load)) begin
      m_shadow[0] = int'(dut_if.dig0);
      m_shadow[1] = int'(dut_if.dig1);
      m_shadow[2] = int'(dut_if.dig2);
      m_shadow[3] = int'(dut_if.dig3);
      m_pend = 1'b0;
    end else if (dut_if.load) begin
      m_pend = 1'b1;
    end
    if (!dut_if.en) begin
      m_an  = 4'hF;
      m_seg = 7'h7F;
    end else if (tick) begin
      m_idx = (m_idx + 1) % 4;
      m_an  = 4'hF ^ 4'(1 << m_idx);
      m_seg = model_shown(m_idx);
    end
  endtask

  // One clock: advance the model at the rising edge, return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic pulse_load();
    dut_if.load = 1'b1;
    cycle();
    dut_if.load = 1'b0;
  endtask

  task automatic run_to_wrap();
    int n;
    n = 0;
    cycle(); n++;
    while (!m_fd && n < 64) begin cycle(); n++; end
    check("wrap_reached", 32'(dut_if.frame_done), 32'd1);
  endtask

  task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
    dut_if.dig3 = 4'(d3); dut_if.dig2 = 4'(d2);
    dut_if.dig1 = 4'(d1); dut_if.dig0 = 4'(d0);
  endtask

  // Asynchronous reset between clock edges, held across one rising edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_an",   32'(dut_if.an),         32'hF);
    check("rst_seg",  32'(dut_if.seg),        32'h7F);
    check("rst_busy", 32'(dut_if.busy),       32'd0);
    check("rst_fd",   32'(dut_if.frame_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    check("an",         32'(dut_if.an),         32'(m_an));
    check("seg",        32'(dut_if.seg),        32'(m_seg));
    check("busy",       32'(dut_if.busy),       32'(m_pend));
    check("frame_done", 32'(dut_if.frame_done), 32'(m_fd));
  end

  initial begin
    rst_n = 1'b0;
    dut_if.en = 1'b0; dut_if.load = 1'b0; dut_if.blank_lz = 1'b0;
    set_digits(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_an",  32'(dut_if.an),  32'hF);
    check("reset_seg", 32'(dut_if.seg), 32'h7F);
    rst_n = 1'b1;
    dut_if.en = 1'b1;

    // Free-running scan of an all-zero shadow.
    for (int c = 1; c <= 17; c++) begin
      cycle();
      if (c == 3)  check("scan_pre_tick_an", 32'(dut_if.an), 32'hF);
      if (c == 4)  check("scan_d1_an",  32'(dut_if.an), 32'b1101);
      if (c == 4)  check("scan_d1_seg", 32'(dut_if.seg), 32'b1000000);
      if (c == 8)  check("scan_d2_an",  32'(dut_if.an), 32'b1011);
      if (c == 12) check("scan_d3_an",  32'(dut_if.an), 32'b0111);
      if (c == 16) check("scan_d0_an",  32'(dut_if.an), 32'b1110);
      if (c == 16) check("scan_fd",     32'(dut_if.frame_done), 32'd1);
      if (c == 17) check("scan_fd_off", 32'(dut_if.frame_done), 32'd0);
    end

    // Load mid-frame: 2,1,9,7 shown from the next frame.
    set_digits(2, 1, 9, 7);
    pulse_load();
    check("load_busy", 32'(dut_if.busy), 32'd1);
    run_to_wrap();
    check("load_busy_clr", 32'(dut_if.busy), 32'd0);
    check("load_d0_an",  32'(dut_if.an),  32'b1110);
    check("load_d0_seg", 32'(dut_if.seg), 32'b1111000);
    check("pin_model_d0", 32'(m_seg), 32'b1111000);
    repeat (P) cycle();
    check("load_d1_seg", 32'(dut_if.seg), 32'b0010000);
    repeat (P) cycle();
    check("load_d2_seg", 32'(dut_if.seg), 32'b1111001);
    repeat (P) cycle();
    check("load_d3_an",  32'(dut_if.an),  32'b0111);
    check("load_d3_seg", 32'(dut_if.seg), 32'b0100100);
    check("pin_model_d3", 32'(m_seg), 32'b0100100);

    // Leading-zero blanking of 0,0,5,0.
    set_digits(0, 0, 5, 0);
    dut_if.blank_lz = 1'b1;
    pulse_load();
    run_to_wrap();
    check("lz_d0_seg", 32'(dut_if.seg), 32'b1000000);
    repeat (P) cycle();
    check("lz_d1_seg", 32'(dut_if.seg), 32'b0010010);
    repeat (P) cycle();
    check("lz_d2_seg", 32'(dut_if.seg), 32'h7F);
    check("pin_model_lz", 32'(m_seg), 32'h7F);
    repeat (P) cycle();
    check("lz_d3_seg", 32'(dut_if.seg), 32'h7F);
    dut_if.blank_lz = 1'b0;
    repeat (P) cycle();
    repeat (P) cycle();
    repeat (P) cycle();
    check("nolz_d2_seg", 32'(dut_if.seg), 32'b1000000);
    repeat (P) cycle();
    check("nolz_d3_seg", 32'(dut_if.seg), 32'b1000000);

    // Out-of-range code on digit 0.
    set_digits(0, 0, 0, 12);
    dut_if.blank_lz = 1'b1;
    pulse_load();
    run_to_wrap();
    check("err_d0_seg", 32'(dut_if.seg), 32'b0000110);
    for (int k = 1; k < 4; k++) begin
      repeat (P) cycle();
      check("err_upper_blank", 32'(dut_if.seg), 32'h7F);
    end

    // Disable mid-frame for 10 clocks with a load requested meanwhile.
    dut_if.blank_lz = 1'b0;
    run_to_wrap();
    cycle();
    cycle();
    dut_if.en = 1'b0;
    set_digits(4, 3, 8, 6);
    pulse_load();
    check("dis_an",  32'(dut_if.an),  32'hF);
    check("dis_seg", 32'(dut_if.seg), 32'h7F);
    repeat (9) cycle();
    check("dis_busy_held", 32'(dut_if.busy), 32'd1);
    check("dis_fd", 32'(dut_if.frame_done), 32'd0);
    dut_if.en = 1'b1;
    cycle();
    check("resume_still_blank", 32'(dut_if.an), 32'hF);
    cycle();
    check("resume_d1_an", 32'(dut_if.an), 32'b1101);

    // Reset while a load is pending: the capture must be discarded.
    do_reset();
    repeat (P) cycle();
    check("post_rst_d1_an", 32'(dut_if.an), 32'b1101);
    run_to_wrap();
    check("post_rst_no_capture", 32'(dut_if.seg), 32'b1000000);
    check("post_rst_busy", 32'(dut_if.busy), 32'd0);

    // Randomized traffic, compared every cycle against the model.
    for (int r = 0; r < 2500; r++) begin
      dut_if.en   = ($urandom % 8) != 0;
      dut_if.load = ($urandom % 12) == 0;
      if (($urandom % 10) == 0)
        set_digits(($urandom % 2) ? 0 : int'($urandom % 16),
                   ($urandom % 2) ? 0 : int'($urandom % 16),
                   ($urandom % 2) ? 0 : int'($urandom % 16),
                   int'($urandom % 16));
      if (($urandom % 40) == 0) dut_if.blank_lz = ~dut_if.blank_lz;
      if (($urandom % 600) == 0) do_reset();
      else cycle();
    end

    dut_if.load = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
